// File: rtl/div_issue_queue.sv
// div_issue_queue: buffers divider operand pairs in a FIFO, issues them one at a time,
// and holds each quotient (or a watchdog error) under a valid/ready handshake.
module div_issue_queue #(
   parameter int W       = 10,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic                   clk,
   input  logic                   sclr,
   input  logic                   in_valid,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   output logic                   in_ready,
   output logic [W-1:0]           div_a,
   output logic [W-1:0]           div_b,
   output logic                   div_start,
   input  logic                   div_busy,
   input  logic                   div_valid,
   input  logic [W-1:0]           div_q,
   input  logic                   div_dvz,
   input  logic                   div_ovf,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [W-1:0]           res_q,
   output logic                   res_dvz,
   output logic                   res_ovf,
   output logic                   res_err,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

   state_e state_q, state_d;
   logic [2*W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] wd_q, wd_d;
   logic [2*W-1:0] op_q, op_d;
   logic [W+2:0] out_q, out_d;
   logic push, pop;

   assign in_ready = cnt_q < FULL && !sclr;
   assign push = in_valid && in_ready;
   assign pop = state_q == ISSUE;
   assign wr_d = wr_q + AW'(push);
   assign rd_d = rd_q + AW'(pop);
   assign cnt_d = cnt_q + CW'(push) - CW'(pop);
   assign {div_a, div_b} = op_q;
   assign div_start = state_q == ISSUE;
   assign res_valid = state_q == HOLD;
   assign {res_q, res_dvz, res_ovf, res_err} = out_q;
   assign count = cnt_q;

   always_comb begin
      state_d = state_q;
      op_d = op_q;
      out_d = out_q;
      wd_d = wd_q;
      case (state_q)
         IDLE: if (|cnt_q && !div_busy) begin
            op_d = mem[rd_q];
            state_d = ISSUE;
         end
         ISSUE: begin
            wd_d = '0;
            state_d = WAIT;
         end
         // a result arriving on the expiry cycle takes priority over the error
         WAIT: if (div_valid) begin
            out_d = {div_q, div_dvz, div_ovf, 1'b0};
            state_d = HOLD;
         end else if (wd_q == WD_LAST) begin
            out_d = {{(W + 2){1'b0}}, 1'b1};
            state_d = HOLD;
         end else begin
            wd_d = wd_q + TW'(1);
         end
         HOLD: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= {in_a, in_b};
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= IDLE;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         wd_q <= '0;
         op_q <= '0;
         out_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         wd_q <= wd_d;
         op_q <= op_d;
         out_q <= out_d;
      end
   end
endmodule

// File: tb/tb_div_issue_queue.sv
// tb_div_issue_queue: drives div_issue_queue against a behavioural divider and an
// in-order operand/result queue model; inputs change and outputs are sampled on negedges.
module tb_div_issue_queue;
   localparam int W = 10;
   localparam int DEPTH = 4;
   localparam int TIMEOUT = 31;

   logic clk = 0, sclr = 1, in_valid = 0, res_ready = 0, hold_busy = 0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic in_ready, div_start, res_valid, res_dvz, res_ovf, res_err, div_busy;
   logic [W-1:0] div_a, div_b, res_q;
   logic [$clog2(DEPTH):0] count;
   logic div_valid = 0, div_dvz = 0, div_ovf = 0, m_busy = 0;
   logic [W-1:0] div_q = '0, m_a = '0, m_b = '0, st_a = '0, st_b = '0;
   int lat = 4, m_cnt = 0, errors = 0, checks = 0, n_starts = 0;
   bit resp_en = 1, m_pend = 0;
   logic [W-1:0] pa[$], pb[$], ia[$], ib[$], ra[$], rb[$];

   assign div_busy = m_busy | hold_busy;
   always #5 clk = ~clk;

   div_issue_queue #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .sclr(sclr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_ready(in_ready), .div_a(div_a), .div_b(div_b), .div_start(div_start),
      .div_busy(div_busy), .div_valid(div_valid), .div_q(div_q), .div_dvz(div_dvz),
      .div_ovf(div_ovf), .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
      .res_dvz(res_dvz), .res_ovf(res_ovf), .res_err(res_err), .count(count)
   );

   // divider behaviour: quotient saturates on zero divisor; ovf flags a zero quotient
   function automatic logic [W-1:0] mq(input logic [W-1:0] a, input logic [W-1:0] b);
      return b == 0 ? '1 : a / b;
   endfunction

   function automatic logic mo(input logic [W-1:0] a, input logic [W-1:0] b);
      return b != 0 && a < b;
   endfunction

   // divider model: valid is sampled by the DUT exactly lat edges after it enters WAIT
   always @(negedge clk) begin
      div_valid = 0;
      if (m_pend) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_pend = 0;
            m_busy = 0;
            if (resp_en) begin
               div_valid = 1;
               div_q = mq(m_a, m_b);
               div_dvz = m_b == 0;
               div_ovf = mo(m_a, m_b);
            end
         end
      end
      if (div_start) begin
         m_pend = 1;
         m_cnt = lat;
         m_a = div_a;
         m_b = div_b;
         m_busy = 1;
      end
   end

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
      in_valid = 1;
      in_a = a;
      in_b = b;
      if (track) begin
         ia.push_back(a);
         ib.push_back(b);
         ra.push_back(a);
         rb.push_back(b);
      end
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (!div_start && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!div_start) n = -1;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (div_start) begin
            n_starts++;
            st_a = div_a;
            st_b = div_b;
         end
      end while (!res_valid && n < 200);
      if (!res_valid) n = -1;
   endtask

   task automatic handshake();
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
   endtask

   // streams pa/pb through the DUT; issues and results are checked against the push order
   task automatic run(input string name, input int want, input int rdy_pct, input int budget);
      int got = 0, cyc = 0;
      bit pv = 0, phs = 0, ps = 0, hs;
      logic [W+2:0] snap = '0;
      logic [W-1:0] ea, eb;
      while (got < want && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (div_start) begin
            ea = ia.size() > 0 ? ia[0] : '1;
            eb = ib.size() > 0 ? ib[0] : '1;
            checks++;
            if (ps || ia.size() == 0 || div_a !== ea || div_b !== eb) begin
               errors++;
               $display("FAIL %s issue: a=%0d b=%0d wide=%0b, expected a=%0d b=%0d", name, div_a, div_b, ps, ea, eb);
            end
            if (ia.size() > 0) begin
               void'(ia.pop_front());
               void'(ib.pop_front());
            end
         end
         if (pv && !phs) begin
            checks++;
            if (res_valid !== 1'b1 || {res_q, res_dvz, res_ovf, res_err} !== snap) begin
               errors++;
               $display("FAIL %s hold: valid=%0b res=%h, expected valid=1 res=%h", name, res_valid, {res_q, res_dvz, res_ovf, res_err}, snap);
            end
         end
         res_ready = $urandom_range(99) < rdy_pct;
         hs = res_valid && res_ready;
         if (hs) begin
            ea = ra.size() > 0 ? ra[0] : '0;
            eb = rb.size() > 0 ? rb[0] : '0;
            checks++;
            if (ra.size() == 0 || {res_q, res_dvz, res_ovf, res_err} !== {mq(ea, eb), eb == 0, mo(ea, eb), 1'b0}) begin
               errors++;
               $display("FAIL %s result: q=%0d dvz=%0b ovf=%0b err=%0b, expected q=%0d dvz=%0b ovf=%0b err=0",
                        name, res_q, res_dvz, res_ovf, res_err, mq(ea, eb), eb == 0, mo(ea, eb));
            end
            if (ra.size() > 0) begin
               void'(ra.pop_front());
               void'(rb.pop_front());
            end
            got++;
         end
         in_valid = pa.size() > 0 && $urandom_range(3) != 0;
         if (pa.size() > 0) begin
            in_a = pa[0];
            in_b = pb[0];
         end
         if (in_valid && in_ready) begin
            ia.push_back(in_a);
            ib.push_back(in_b);
            ra.push_back(in_a);
            rb.push_back(in_b);
            void'(pa.pop_front());
            void'(pb.pop_front());
         end
         pv = res_valid;
         phs = hs;
         ps = div_start;
         snap = {res_q, res_dvz, res_ovf, res_err};
      end
      @(negedge clk);
      in_valid = 0;
      res_ready = 0;
      checks++;
      if (got != want || ia.size() != 0 || ra.size() != 0 || pa.size() != 0) begin
         errors++;
         $display("FAIL %s drain: results=%0d left issue=%0d result=%0d push=%0d, expected results=%0d none left",
                  name, got, ia.size(), ra.size(), pa.size(), want);
      end
   endtask

   task automatic test_reset();
      sclr = 1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset in_ready during sclr: %0b, expected 0", in_ready);
      end
      checks++;
      if ({count, res_valid, div_start, div_a, div_b, res_q, res_dvz, res_ovf, res_err} !== '0) begin
         errors++;
         $display("FAIL reset state: count=%0d rv=%0b start=%0b a=%0d b=%0d q=%0d dvz=%0b ovf=%0b err=%0b, expected all 0",
                  count, res_valid, div_start, div_a, div_b, res_q, res_dvz, res_ovf, res_err);
      end
      sclr = 0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset in_ready after sclr: %0b, expected 1", in_ready);
      end
   endtask

   task automatic test_single();
      int n;
      lat = 5;
      resp_en = 1;
      push(100, 7, 0);
      checks++;
      if (count !== 1 || div_start !== 1'b0) begin
         errors++;
         $display("FAIL single push: count=%0d start=%0b, expected 1 0", count, div_start);
      end
      @(negedge clk);
      checks++;
      if (div_start !== 1'b1 || div_a !== 100 || div_b !== 7) begin
         errors++;
         $display("FAIL single issue: start=%0b a=%0d b=%0d, expected 1 100 7", div_start, div_a, div_b);
      end
      n_starts = 0;
      wait_res(n);
      checks++;
      if (n != lat + 1 || n_starts != 0) begin
         errors++;
         $display("FAIL single latency: cycles=%0d extra_starts=%0d, expected %0d 0", n, n_starts, lat + 1);
      end
      checks++;
      if ({res_q, res_dvz, res_ovf, res_err} !== {10'd14, 3'b000}) begin
         errors++;
         $display("FAIL single result: q=%0d dvz=%0b ovf=%0b err=%0b, expected 14 0 0 0", res_q, res_dvz, res_ovf, res_err);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_q !== 14) begin
         errors++;
         $display("FAIL single hold: valid=%0b q=%0d, expected 1 14", res_valid, res_q);
      end
      handshake();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL single release: valid=%0b, expected 0", res_valid);
      end
   endtask

   task automatic test_div_zero();
      int n;
      lat = 3;
      push(50, 0, 0);
      wait_res(n);
      checks++;
      if (n < 0 || {res_q, res_dvz, res_ovf, res_err} !== {{W{1'b1}}, 3'b100}) begin
         errors++;
         $display("FAIL divzero: wait=%0d q=%0d dvz=%0b ovf=%0b err=%0b, expected q=%0d dvz=1 ovf=0 err=0",
                  n, res_q, res_dvz, res_ovf, res_err, {W{1'b1}});
      end
      handshake();
   endtask

   task automatic test_random(input string name, input int n);
      lat = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
         pa.push_back(W'($urandom));
         pb.push_back($urandom_range(0, 7) == 0 ? '0 : W'($urandom));
      end
      run(name, n, 60, 4000);
   endtask

   task automatic test_backpressure();
      bit started = 0;
      hold_busy = 1;
      lat = 3;
      for (int i = 0; i < DEPTH; i++) push(W'($urandom), W'($urandom_range(0, 40)), 1);
      checks++;
      if (count !== DEPTH || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL backpressure full: count=%0d in_ready=%0b, expected %0d 0", count, in_ready, DEPTH);
      end
      in_valid = 1;
      in_a = 1;
      in_b = 1;
      repeat (3) begin
         @(negedge clk);
         if (div_start) started = 1;
      end
      in_valid = 0;
      checks++;
      if (count !== DEPTH || in_ready !== 1'b0 || started) begin
         errors++;
         $display("FAIL backpressure hold: count=%0d in_ready=%0b started=%0b, expected %0d 0 0", count, in_ready, started, DEPTH);
      end
      pa.push_back(W'($urandom));
      pb.push_back(W'($urandom_range(1, 40)));
      hold_busy = 0;
      run("backpressure", DEPTH + 1, 100, 600);
   endtask

   task automatic test_consumer_stall();
      int n;
      logic [W+2:0] snap;
      lat = 2;
      hold_busy = 1;
      for (int i = 0; i < 3; i++) push(W'($urandom), W'($urandom_range(1, 30)), 1);
      hold_busy = 0;
      n_starts = 0;
      wait_res(n);
      checks++;
      if (n < 0 || n_starts != 1 || st_a !== ia[0] || st_b !== ib[0]) begin
         errors++;
         $display("FAIL stall first issue: wait=%0d starts=%0d a=%0d b=%0d, expected 1 start a=%0d b=%0d", n, n_starts, st_a, st_b, ia[0], ib[0]);
      end
      void'(ia.pop_front());
      void'(ib.pop_front());
      snap = {res_q, res_dvz, res_ovf, res_err};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || div_start !== 1'b0 || {res_q, res_dvz, res_ovf, res_err} !== snap) begin
            errors++;
            $display("FAIL stall cycle %0d: valid=%0b start=%0b res=%h, expected 1 0 %h", i, res_valid, div_start, {res_q, res_dvz, res_ovf, res_err}, snap);
         end
      end
      run("stall_drain", 3, 100, 400);
   endtask

   task automatic test_watchdog();
      bit en[3] = '{0, 1, 1};
      bit ee[3] = '{1, 0, 1};
      int ls[3] = '{3, TIMEOUT, TIMEOUT + 1};
      int n;
      logic [W-1:0] a, b;
      logic [W+2:0] exp_r;
      for (int k = 0; k < 3; k++) begin
         resp_en = en[k];
         lat = ls[k];
         a = W'($urandom_range(1, 1023));
         b = W'($urandom_range(1, 15));
         exp_r = ee[k] ? {{(W + 2){1'b0}}, 1'b1} : {mq(a, b), 1'b0, mo(a, b), 1'b0};
         push(a, b, 0);
         wait_start(n);
         wait_res(n);
         checks++;
         if (n - 1 != TIMEOUT) begin
            errors++;
            $display("FAIL watchdog case %0d timing: cycles in WAIT=%0d, expected %0d", k, n - 1, TIMEOUT);
         end
         checks++;
         if ({res_q, res_dvz, res_ovf, res_err} !== exp_r) begin
            errors++;
            $display("FAIL watchdog case %0d result: res=%h, expected %h", k, {res_q, res_dvz, res_ovf, res_err}, exp_r);
         end
         repeat (3) @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || {res_q, res_dvz, res_ovf, res_err} !== exp_r) begin
            errors++;
            $display("FAIL watchdog case %0d hold: valid=%0b res=%h, expected 1 %h", k, res_valid, {res_q, res_dvz, res_ovf, res_err}, exp_r);
         end
         handshake();
         repeat (2) @(negedge clk);
      end
      resp_en = 1;
   endtask

   task automatic test_reset_midop();
      int n;
      bit bad = 0;
      lat = 10;
      hold_busy = 1;
      for (int i = 0; i < 3; i++) push(W'($urandom), W'($urandom_range(1, 99)), 0);
      hold_busy = 0;
      wait_start(n);
      repeat (3) @(negedge clk);
      checks++;
      if (n < 0 || count !== 2 || div_start !== 1'b0) begin
         errors++;
         $display("FAIL midop setup: wait=%0d count=%0d start=%0b, expected count 2 start 0", n, count, div_start);
      end
      sclr = 1;
      @(negedge clk);
      checks++;
      if ({count, res_valid, div_start, in_ready} !== '0) begin
         errors++;
         $display("FAIL midop reset: count=%0d valid=%0b start=%0b in_ready=%0b, expected all 0", count, res_valid, div_start, in_ready);
      end
      sclr = 0;
      repeat (15) begin
         @(negedge clk);
         if (res_valid || div_start || count != 0) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL midop stale: valid, start or count became nonzero after reset, expected all 0");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_div_zero();
      test_random("random", 12);
      test_backpressure();
      test_consumer_stall();
      test_watchdog();
      test_reset_midop();
      test_random("after_reset", 8);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
